// File: rtl/stim_gen_pkg.sv
// Shared types and default widths for the operand-pair stimulus generator.
package stim_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_DEPTH  = 8;
  localparam int unsigned DEF_GAP_W  = 4;
  localparam int unsigned DEF_CNT_W  = 16;

endpackage

// File: rtl/stim_pair_buf.sv
// Operand-pair storage: one synchronous write port with its own write pointer,
// one asynchronous read port. Contents are not reset.
module stim_pair_buf
  import stim_gen_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     we,
  input  logic [2*DATA_W-1:0]      wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [2*DATA_W-1:0]      rdata
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [2*DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]       wr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
    end else if (we) begin
      wr_ptr <= wr_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (we && !clr) begin
      mem[wr_ptr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/operand_stim_gen.sv
// Loadable operand-pair sequencer replaying buffered (a,b) pairs over valid/ready.
// Optional STIM_GEN_CHECKSUM_EN adds chk_sum, the running XOR of op_a^op_b per handshake.
module operand_stim_gen
  import stim_gen_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned GAP_W  = DEF_GAP_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [DATA_W-1:0]      ld_a,
  input  logic [DATA_W-1:0]      ld_b,
  input  logic                   clear,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   loop_mode,
  input  logic [GAP_W-1:0]       gap_cycles,
  output logic                   op_valid,
  input  logic                   op_ready,
  output logic [DATA_W-1:0]      op_a,
  output logic [DATA_W-1:0]      op_b,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       sent_count
`ifdef STIM_GEN_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]      chk_sum
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  state_e              state, state_nx;
  logic [AW-1:0]       rd_ptr, rd_ptr_nx;
  logic [LW-1:0]       level_nx;
  logic [GAP_W-1:0]    gap_q, gap_nx;
  logic [GAP_W-1:0]    gap_cnt, gap_cnt_nx;
  logic                loop_q, loop_nx;
  logic                stop_q, stop_nx;
  logic [CNT_W-1:0]    sent_nx;
  logic [DATA_W-1:0]   op_a_nx, op_b_nx;
  logic                buf_we, buf_clr;
  logic [2*DATA_W-1:0] buf_rdata;
  logic                hs, last, stop_seen;

  stim_pair_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (buf_clr),
    .we    (buf_we),
    .wdata ({ld_a, ld_b}),
    .raddr (rd_ptr_nx),
    .rdata (buf_rdata)
  );

  // Next-state and next-output logic; every output flop is loaded from these values.
  always_comb begin
    state_nx   = state;
    rd_ptr_nx  = rd_ptr;
    level_nx   = level;
    gap_nx     = gap_q;
    gap_cnt_nx = gap_cnt;
    loop_nx    = loop_q;
    stop_nx    = stop_q;
    sent_nx    = sent_count;
    op_a_nx    = op_a;
    op_b_nx    = op_b;
    buf_we     = 1'b0;
    buf_clr    = 1'b0;
    hs         = op_valid && op_ready;
    last       = (rd_ptr == AW'(level - LW'(1)));
    stop_seen  = stop_q || stop;

    unique case (state)
      IDLE: begin
        if (clear) begin
          buf_clr  = 1'b1;
          level_nx = '0;
        end else if (ld_valid && ld_ready) begin
          buf_we   = 1'b1;
          level_nx = level + LW'(1);
        end
        if (start) begin
          rd_ptr_nx = '0;
          sent_nx   = '0;
          if (level != '0) begin
            state_nx = SEND;
            loop_nx  = loop_mode;
            gap_nx   = gap_cycles;
          end else begin
            state_nx = DONE;
          end
        end
      end
      SEND: begin
        if (stop) stop_nx = 1'b1;
        if (hs) begin
          if (sent_count != '1) sent_nx = sent_count + CNT_W'(1);
          if (stop_seen || (last && !loop_q)) begin
            state_nx = DONE;
          end else begin
            rd_ptr_nx = last ? '0 : rd_ptr + AW'(1);
            if (gap_q != '0) begin
              state_nx   = GAP;
              gap_cnt_nx = gap_q;
            end
          end
        end
      end
      GAP: begin
        if (stop) stop_nx = 1'b1;
        if (stop_seen) begin
          state_nx = DONE;
        end else if (gap_cnt == GAP_W'(1)) begin
          state_nx = SEND;
        end else begin
          gap_cnt_nx = gap_cnt - GAP_W'(1);
        end
      end
      DONE: begin
        state_nx = IDLE;
        stop_nx  = 1'b0;
      end
      default: state_nx = IDLE;
    endcase

    // The presented pair follows the read pointer whenever a pair is about to be offered.
    if (state_nx == SEND) begin
      op_a_nx = buf_rdata[2*DATA_W-1:DATA_W];
      op_b_nx = buf_rdata[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rd_ptr     <= '0;
      level      <= '0;
      gap_q      <= '0;
      gap_cnt    <= '0;
      loop_q     <= 1'b0;
      stop_q     <= 1'b0;
      sent_count <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_valid   <= 1'b0;
      ld_ready   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nx;
      rd_ptr     <= rd_ptr_nx;
      level      <= level_nx;
      gap_q      <= gap_nx;
      gap_cnt    <= gap_cnt_nx;
      loop_q     <= loop_nx;
      stop_q     <= stop_nx;
      sent_count <= sent_nx;
      op_a       <= op_a_nx;
      op_b       <= op_b_nx;
      op_valid   <= (state_nx == SEND);
      ld_ready   <= (state_nx == IDLE) && (level_nx < LW'(DEPTH));
      busy       <= (state_nx != IDLE);
      done       <= (state_nx == DONE);
    end
  end

`ifdef STIM_GEN_CHECKSUM_EN
  logic [DATA_W-1:0] chk_nx;

  always_comb begin
    chk_nx = chk_sum;
    if (state == IDLE && start) begin
      chk_nx = '0;
    end else if (hs) begin
      chk_nx = chk_sum ^ op_a ^ op_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_sum <= '0;
    end else begin
      chk_sum <= chk_nx;
    end
  end
`endif

endmodule

// File: tb/tb_operand_stim_gen.sv
// Scoreboard bench for operand_stim_gen: expected pairs queued at start, popped by a monitor.
module tb_operand_stim_gen;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int GW    = 4;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ld_valid = 1'b0, ld_ready;
  logic [DW-1:0] ld_a = '0, ld_b = '0;
  logic          clear = 1'b0, start = 1'b0, stop = 1'b0, loop_mode = 1'b0;
  logic [GW-1:0] gap_cycles = '0;
  logic          op_valid, op_ready = 1'b0;
  logic [DW-1:0] op_a, op_b;
  logic          busy, done;
  logic [3:0]    level;
  logic [CW-1:0] sent_count;
`ifdef STIM_GEN_CHECKSUM_EN
  logic [DW-1:0] chk_sum;
`endif

  operand_stim_gen dut (
    .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_a(ld_a), .ld_b(ld_b), .clear(clear), .start(start), .stop(stop),
    .loop_mode(loop_mode), .gap_cycles(gap_cycles), .op_valid(op_valid),
    .op_ready(op_ready), .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
    .level(level), .sent_count(sent_count)
`ifdef STIM_GEN_CHECKSUM_EN
    , .chk_sum(chk_sum)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model state
  logic [2*DW-1:0] mbuf[$];
  logic [2*DW-1:0] exp_q[$];
  logic [DW-1:0]   mchk;
  int              exp_gap;
  bit              exp_nonempty;
  int              hs_count, done_cnt, cyc, last_hs_cyc;
  logic            prev_valid, prev_ready;
  logic [2*DW-1:0] prev_pair;

  // Monitor: sampled at the falling edge, a handshake here completes at the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      cyc++;
      if (prev_valid && !prev_ready) begin
        chk("hold_valid", 64'(op_valid), 64'd1);
        chk("hold_pair", 64'({op_a, op_b}), 64'(prev_pair));
      end
      if (op_valid && !prev_valid && hs_count > 0)
        chk("gap_len", 64'(cyc - last_hs_cyc), 64'(exp_gap + 1));
      if (done) begin
        done_cnt++;
        if (exp_nonempty) chk("done_after_last", 64'(last_hs_cyc), 64'(cyc - 1));
      end
      if (op_valid && op_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_xfer: got %0h expected none", {op_a, op_b});
        end else begin
          chk("xfer_pair", 64'({op_a, op_b}), 64'(exp_q.pop_front()));
        end
        hs_count++;
        last_hs_cyc = cyc;
      end
      prev_valid = op_valid;
      prev_ready = op_ready;
      prev_pair  = {op_a, op_b};
    end
  end

  // All driver tasks are entered and left at 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pair(input logic [DW-1:0] a, input logic [DW-1:0] b);
    ld_valid = 1'b1;
    ld_a = a;
    ld_b = b;
    if (mbuf.size() < DEPTH) mbuf.push_back({a, b});
    step();
    ld_valid = 1'b0;
    chk("level_after_load", 64'(level), 64'(mbuf.size()));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    mbuf.delete();
    chk("level_after_clear", 64'(level), 64'd0);
    chk("ld_ready_after_clear", 64'(ld_ready), 64'd1);
  endtask

  // One playback: model computes the expected transfer list from buffer, mode and stop point.
  task automatic run(input bit lp, input int gap, input int stop_after, input int hold,
                     input bit rnd, input bit clr_busy);
    int n, nexp, d0;
    bit got;
    n = mbuf.size();
    if (n == 0) nexp = 0;
    else if (hold > 0) nexp = 1;
    else if (lp) nexp = stop_after;
    else nexp = n;
    exp_q.delete();
    mchk = '0;
    for (int i = 0; i < nexp; i++) begin
      exp_q.push_back(mbuf[i % n]);
      mchk ^= mbuf[i % n][2*DW-1:DW] ^ mbuf[i % n][DW-1:0];
    end
    exp_nonempty = (nexp > 0);
    exp_gap  = gap;
    hs_count = 0;
    d0       = done_cnt;
    loop_mode  = lp;
    gap_cycles = GW'(gap);
    start = 1'b1;
    step();
    start = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (hold > 0 && c < hold) op_ready = 1'b0;
      else op_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (hold > 0 && c == 2) stop = 1'b1;
      if (stop_after > 0 && hs_count >= stop_after - 1) stop = 1'b1;
      clear = clr_busy && (c == 1);
      step();
    end
    stop = 1'b0;
    clear = 1'b0;
    op_ready = 1'b0;
    chk("done_seen", 64'(got), 64'd1);
    chk("sent_count", 64'(sent_count), 64'(nexp));
`ifdef STIM_GEN_CHECKSUM_EN
    chk("chk_sum", 64'(chk_sum), 64'(mchk));
`endif
    step();
    chk("busy_after_done", 64'(busy), 64'd0);
    chk("done_pulse_count", 64'(done_cnt - d0), 64'd1);
    chk("done_single_cycle", 64'(done), 64'd0);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    chk("level_kept", 64'(level), 64'(mbuf.size()));
  endtask

  initial begin
    cyc = 0; hs_count = 0; done_cnt = 0; last_hs_cyc = 0; exp_gap = 0; exp_nonempty = 1'b0;
    prev_valid = 1'b0; prev_ready = 1'b0; prev_pair = '0; mchk = '0;
    #12;
    chk("rst_op_valid", 64'(op_valid), 64'd0);
    chk("rst_ld_ready", 64'(ld_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_sent", 64'(sent_count), 64'd0);
    rst_n = 1'b1;
    step();

    // Directed one-shot, back-to-back, then the same buffer with a long gap
    load_pair(8'd3, 8'd5);
    load_pair(8'd1, 8'd2);
    load_pair(8'd2, 8'd1);
    run(1'b0, 0, 0, 0, 1'b0, 1'b0);
    run(1'b0, 9, 0, 0, 1'b0, 1'b0);

    // Loop with stop after five transfers
    do_clear();
    load_pair(8'hA1, 8'h1A);
    load_pair(8'hB2, 8'h2B);
    run(1'b1, 0, 5, 0, 1'b0, 1'b0);
    // Stall with stop raised mid-stall, clear while busy must be ignored
    run(1'b1, 0, 0, 4, 1'b0, 1'b1);

`ifdef STIM_GEN_CHECKSUM_EN
    do_clear();
    load_pair(8'd3, 8'd5);
    load_pair(8'd1, 8'd2);
    run(1'b0, 0, 0, 0, 1'b0, 1'b0);
    chk("chk_sum_fixed", 64'(chk_sum), 64'h05);
`endif

    // Fill to capacity, ninth load dropped
    do_clear();
    for (int i = 0; i < DEPTH; i++) load_pair(DW'($urandom), DW'($urandom));
    chk("ld_ready_full", 64'(ld_ready), 64'd0);
    load_pair(8'hEE, 8'hEE);
    chk("level_full", 64'(level), 64'(DEPTH));
    run(1'b0, 2, 0, 0, 1'b1, 1'b0);

    // Empty buffer start
    do_clear();
    run(1'b0, 0, 0, 0, 1'b0, 1'b0);

    // Randomized one-shot runs
    for (int r = 0; r < 6; r++) begin
      int n;
      do_clear();
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) load_pair(DW'($urandom), DW'($urandom));
      run(1'b0, $urandom_range(0, 3), 0, 0, 1'b1, 1'b0);
    end

    // Reset in the middle of a looping playback
    do_clear();
    load_pair(8'h11, 8'h22);
    load_pair(8'h33, 8'h44);
    exp_q.delete();
    for (int i = 0; i < 20; i++) exp_q.push_back(mbuf[i % 2]);
    exp_nonempty = 1'b1;
    hs_count = 0;
    exp_gap = 0;
    loop_mode = 1'b1;
    gap_cycles = '0;
    op_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #2;
    chk("midrst_op_valid", 64'(op_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_level", 64'(level), 64'd0);
    chk("midrst_sent", 64'(sent_count), 64'd0);
    chk("midrst_ld_ready", 64'(ld_ready), 64'd1);
    op_ready = 1'b0;
    exp_q.delete();
    mbuf.delete();
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_busy", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
